// File: rtl/imm_li_encoder.sv
// Load-immediate expander: turns (rd, 32-bit value) into an RV32I LUI/ADDI word stream.
// Optional short encodings (single ADDI or single LUI) are enabled by defining IMM_LI_SHORT_EN.
module imm_li_encoder #(
    parameter int WORD_LEN = 32,
    parameter int REG_W    = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [REG_W-1:0]    req_rd,
    input  logic [WORD_LEN-1:0] req_value,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [WORD_LEN-1:0] instr_data,
    output logic                instr_last
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_LUI  = 2'd1,
        EMIT_ADDI = 2'd2
    } state_t;

    localparam logic [WORD_LEN-1:0] NOP_WORD = 32'h0000_0013;

    function automatic logic [WORD_LEN-1:0] enc_lui(input logic [19:0] hi20,
                                                    input logic [REG_W-1:0] rd);
        return {hi20, rd, 7'b0110111};
    endfunction

    function automatic logic [WORD_LEN-1:0] enc_addi(input logic [11:0] lo12,
                                                     input logic [REG_W-1:0] rs1,
                                                     input logic [REG_W-1:0] rd);
        return {lo12, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    state_t                state_r, state_s;
    logic [REG_W-1:0]      rd_r, rd_s;
    logic [11:0]           lo12_r, lo12_s;
    logic [WORD_LEN-1:0]   instr_data_r, data_s;
    logic                  instr_last_r, last_s;
    logic                  instr_valid_r, valid_s;
    logic                  req_ready_r, ready_s;
    logic [19:0]           hi20_s;
`ifdef IMM_LI_SHORT_EN
    logic                  small_s;
`endif

    // Upper part rounded so the sign-extended lo12 of ADDI lands on the exact value.
    assign hi20_s = req_value[31:12] + {19'd0, req_value[11]};
`ifdef IMM_LI_SHORT_EN
    assign small_s = (&req_value[31:11]) | (~|req_value[31:11]);
`endif

    assign req_ready   = req_ready_r;
    assign instr_valid = instr_valid_r;
    assign instr_data  = instr_data_r;
    assign instr_last  = instr_last_r;

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s = state_r;
        rd_s    = rd_r;
        lo12_s  = lo12_r;
        data_s  = instr_data_r;
        last_s  = instr_last_r;
        valid_s = instr_valid_r;
        ready_s = req_ready_r;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    rd_s    = req_rd;
                    lo12_s  = req_value[11:0];
                    valid_s = 1'b1;
                    ready_s = 1'b0;
                    if (req_rd == {REG_W{1'b0}}) begin
                        state_s = EMIT_ADDI;
                        data_s  = NOP_WORD;
                        last_s  = 1'b1;
                    end
`ifdef IMM_LI_SHORT_EN
                    else if (small_s) begin
                        state_s = EMIT_ADDI;
                        data_s  = enc_addi(req_value[11:0], {REG_W{1'b0}}, req_rd);
                        last_s  = 1'b1;
                    end else if (req_value[11:0] == 12'd0) begin
                        state_s = EMIT_LUI;
                        data_s  = enc_lui(hi20_s, req_rd);
                        last_s  = 1'b1;
                    end
`endif
                    else begin
                        state_s = EMIT_LUI;
                        data_s  = enc_lui(hi20_s, req_rd);
                        last_s  = 1'b0;
                    end
                end else begin
                    ready_s = 1'b1;
                    valid_s = 1'b0;
                end
            end
            EMIT_LUI: begin
                if (instr_ready && instr_last_r) begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                    ready_s = 1'b1;
                    data_s  = {WORD_LEN{1'b0}};
                    last_s  = 1'b0;
                end else if (instr_ready) begin
                    state_s = EMIT_ADDI;
                    data_s  = enc_addi(lo12_r, rd_r, rd_r);
                    last_s  = 1'b1;
                end else begin
                    state_s = EMIT_LUI;
                end
            end
            EMIT_ADDI: begin
                if (instr_ready) begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                    ready_s = 1'b1;
                    data_s  = {WORD_LEN{1'b0}};
                    last_s  = 1'b0;
                end else begin
                    state_s = EMIT_ADDI;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                ready_s = 1'b1;
                data_s  = {WORD_LEN{1'b0}};
                last_s  = 1'b0;
            end
        endcase
    end

    // State, captured request and registered stream outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= IDLE;
            rd_r          <= {REG_W{1'b0}};
            lo12_r        <= 12'd0;
            instr_data_r  <= {WORD_LEN{1'b0}};
            instr_last_r  <= 1'b0;
            instr_valid_r <= 1'b0;
            req_ready_r   <= 1'b1;
        end else begin
            state_r       <= state_s;
            rd_r          <= rd_s;
            lo12_r        <= lo12_s;
            instr_data_r  <= data_s;
            instr_last_r  <= last_s;
            instr_valid_r <= valid_s;
            req_ready_r   <= ready_s;
        end
    end

endmodule
